// File: rtl/bullet_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : bullet_scheduler                                             |
// | Description : Three-slot bullet mover with fire cooldown, collision        |
// |               arbitration against a 6x5 target map and a one-entry hit     |
// |               report buffer with valid/ready handshake.                    |
// |               Optional macro BULLET_SCORE_EN adds a saturating 8-bit       |
// |               score counter of completed hit handshakes.                   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module bullet_scheduler #(
    parameter int SPAWN_Y  = 11,
    parameter int COOLDOWN = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        bullet_tick,
    input  logic        fire_req,
    input  logic [3:0]  player_x,
    input  logic [29:0] alive,
    output logic        fire_ack,
    output logic [2:0]  slot_active,
    output logic [11:0] bullet_x,
    output logic [11:0] bullet_y,
    output logic        hit_valid,
    output logic [2:0]  hit_row,
    output logic [2:0]  hit_col,
    input  logic        hit_ready
`ifdef BULLET_SCORE_EN
    ,
    output logic [7:0]  score
`endif
);

    localparam int             CDW       = (COOLDOWN < 1) ? 1 : $clog2(COOLDOWN + 1);
    localparam logic [CDW-1:0] c_CD_LOAD = CDW'(COOLDOWN);
    localparam logic [3:0]     c_SPAWN_Y = 4'(SPAWN_Y);

    logic [2:0]     r_act;
    logic [11:0]    r_x;
    logic [11:0]    r_y;
    logic [CDW-1:0] r_cd;
    logic           r_hv;
    logic [2:0]     r_hrow;
    logic [2:0]     r_hcol;
    logic           r_ack;

    logic [63:0]    w_alive64;
    logic [3:0]     w_ny   [3];
    logic [5:0]     w_idx  [3];
    logic [2:0]     w_cand;

    logic [2:0]     w_act_n;
    logic [11:0]    w_x_n;
    logic [11:0]    w_y_n;
    logic [CDW-1:0] w_cd_n;
    logic           w_hv_n;
    logic [2:0]     w_hrow_n;
    logic [2:0]     w_hcol_n;
    logic           w_accept;
    logic           w_won;
    logic [1:0]     w_sel;
    logic           w_drain;

    // Zero-extend the map so any 6-bit cell index is in range.
    assign w_alive64 = {34'd0, alive};
    assign w_drain   = r_hv & hit_ready;

    // Per-slot next row and collision-candidate flag for a tick in this cycle.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            w_ny[i]   = r_y[4*i +: 4] - 4'd1;
            w_idx[i]  = 6'(w_ny[i]) * 6'd6 + 6'(r_x[4*i +: 4]);
            w_cand[i] = r_act[i] && (r_y[4*i +: 4] != 4'd0) && (w_ny[i] <= 4'd4)
                        && (r_x[4*i +: 4] <= 4'd5) && w_alive64[w_idx[i]];
        end
    end

    // Next-state: hit drain, tick movement/arbitration, fire acceptance, cooldown.
    always_comb begin
        w_act_n  = r_act;
        w_x_n    = r_x;
        w_y_n    = r_y;
        w_cd_n   = r_cd;
        w_hv_n   = r_hv;
        w_hrow_n = r_hrow;
        w_hcol_n = r_hcol;
        w_won    = 1'b0;
        w_sel    = 2'd0;

        // A drained buffer is still "full" for this cycle's arbitration.
        if (w_drain) begin
            w_hv_n = 1'b0;
        end

        if (bullet_tick) begin
            for (int i = 0; i < 3; i++) begin
                if (r_act[i]) begin
                    if (r_y[4*i +: 4] == 4'd0) begin
                        w_act_n[i] = 1'b0;
                    end else if (!w_cand[i]) begin
                        w_y_n[4*i +: 4] = w_ny[i];
                    end else if (!r_hv && !w_won) begin
                        w_won      = 1'b1;
                        w_act_n[i] = 1'b0;
                        w_hv_n     = 1'b1;
                        w_hrow_n   = w_ny[i][2:0];
                        w_hcol_n   = r_x[4*i+:3];
                    end
                end
            end
            if (r_cd != '0) begin
                w_cd_n = r_cd - 1'b1;
            end
        end

        // Only slots free in the registered state can take a new bullet.
        w_accept = fire_req && (r_cd == '0) && !(&r_act);
        for (int i = 2; i >= 0; i--) begin
            if (!r_act[i]) begin
                w_sel = 2'(i);
            end
        end
        if (w_accept) begin
            w_cd_n = c_CD_LOAD;
            for (int i = 0; i < 3; i++) begin
                if (w_sel == 2'(i)) begin
                    w_act_n[i]      = 1'b1;
                    w_x_n[4*i +: 4] = player_x;
                    w_y_n[4*i +: 4] = c_SPAWN_Y;
                end
            end
        end
    end

    // State register for slots, cooldown, hit buffer and fire acknowledge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_act  <= '0;
            r_x    <= '0;
            r_y    <= '0;
            r_cd   <= '0;
            r_hv   <= 1'b0;
            r_hrow <= '0;
            r_hcol <= '0;
            r_ack  <= 1'b0;
        end else begin
            r_act  <= w_act_n;
            r_x    <= w_x_n;
            r_y    <= w_y_n;
            r_cd   <= w_cd_n;
            r_hv   <= w_hv_n;
            r_hrow <= w_hrow_n;
            r_hcol <= w_hcol_n;
            r_ack  <= w_accept;
        end
    end

`ifdef BULLET_SCORE_EN
    logic [7:0] r_score;

    // Count completed hit handshakes, saturating at the top of the range.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_score <= '0;
        end else if (w_drain && (r_score != 8'hFF)) begin
            r_score <= r_score + 8'd1;
        end
    end

    assign score = r_score;
`endif

    assign fire_ack    = r_ack;
    assign slot_active = r_act;
    assign bullet_x    = r_x;
    assign bullet_y    = r_y;
    assign hit_valid   = r_hv;
    assign hit_row     = r_hrow;
    assign hit_col     = r_hcol;

endmodule
`default_nettype wire

// File: doc/bullet_scheduler.md
BULLET_SCHEDULER -- requirements
Module: bullet_scheduler

Interface
REQ-001 The block SHALL have parameter SPAWN_Y, default 11, the grid row where a new bullet is placed.
REQ-002 The block SHALL have parameter COOLDOWN, default 2, the number of bullet_tick pulses after an accepted fire before the next fire is allowed.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port bullet_tick, input, 1 bit: a one-cycle movement enable.
REQ-006 The block SHALL have port fire_req, input, 1 bit: a one-cycle fire request.
REQ-007 The block SHALL have port player_x, input, 4 bits: the column that a new bullet takes.
REQ-008 The block SHALL have port alive, input, 30 bits: the target occupancy map; bit r*6+c is row r (0..4), column c (0..5).
REQ-009 The block SHALL have port fire_ack, output, 1 bit: a one-cycle pulse that confirms an accepted fire.
REQ-010 The block SHALL have port slot_active, output, 3 bits: one bit per bullet slot.
REQ-011 The block SHALL have port bullet_x, output, 12 bits: packed 4-bit column per slot; slot i uses bits 4i+3:4i.
REQ-012 The block SHALL have port bullet_y, output, 12 bits: packed 4-bit row per slot, same packing as bullet_x.
REQ-013 The block SHALL have ports hit_valid (output, 1 bit), hit_row (output, 3 bits) and hit_col (output, 3 bits): the hit report.
REQ-014 The block SHALL have port hit_ready, input, 1 bit: the consumer's acceptance of the hit report.

Function
REQ-015 All outputs SHALL be registered; bullet_x, bullet_y, slot_active and the hit report SHALL reflect a tick's effects in the cycle after that tick.
REQ-016 Fire acceptance SHALL require three things: fire_req=1, cooldown counter =0, and at least one slot inactive in the registered state.
REQ-017 An accepted fire SHALL go to the lowest-index free slot with x=player_x, y=SPAWN_Y, and SHALL pulse fire_ack for one cycle.
REQ-018 An accepted fire SHALL load the cooldown counter with COOLDOWN.
REQ-019 A fire request that is not accepted SHALL be dropped with no ack and no state change.
REQ-020 The cooldown counter SHALL decrement by one on each bullet_tick while it is nonzero.
REQ-021 A slot filled by a fire in the same cycle as a bullet_tick SHALL NOT move on that tick.
REQ-022 A slot freed in a cycle SHALL become available to fire_req from the next cycle onward.
REQ-023 On bullet_tick, each active slot with y=0 SHALL be freed (the bullet exits the top), with no hit generated.
REQ-024 On bullet_tick, each other active slot SHALL evaluate ny=y-1; it is a collision candidate when ny<=4, x<=5 and alive[ny*6+x]=1.
REQ-025 An active slot that is not a collision candidate SHALL move to y=ny.
REQ-026 Collision arbitration: the lowest-index candidate SHALL win only if the hit buffer is empty at the start of the cycle.
REQ-027 The winning slot SHALL be freed and the buffer loaded with (ny, x); hit_valid SHALL be 1 from the next cycle.
REQ-028 Losing candidates, and all candidates while the buffer is full, SHALL stall at their current y with no move.
REQ-029 hit_valid, hit_row and hit_col SHALL hold stable until the cycle in which hit_valid=1 and hit_ready=1; the buffer SHALL then clear in the next cycle.
REQ-030 A buffer drained in a cycle SHALL NOT accept a new hit in that same cycle.
REQ-031 Bullets with x>5 SHALL never collide and SHALL exit normally.
REQ-032 alive SHALL be sampled only in the tick cycle; changes to alive between ticks SHALL have no effect.

Reset
REQ-033 While rst=1, asynchronously: slot_active=0, bullet_x=0, bullet_y=0, hit_valid=0, hit_row=0, hit_col=0, fire_ack=0, cooldown=0, and score=0 when score is present.
REQ-034 Assertion of rst mid-flight or mid-handshake SHALL discard all bullets and any pending hit without emitting a report.

Configuration
REQ-035 With macro BULLET_SCORE_EN defined, the block SHALL add output score (8 bits).
REQ-036 score SHALL increment by 1 on each hit handshake (hit_valid=1 and hit_ready=1) and SHALL saturate at 255.
REQ-037 Without BULLET_SCORE_EN, the score port and its counter SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-038 Scenario: player_x=2, fire_req pulse, alive=0 -> fire_ack 1 cycle; slot0 active, y=11; after 11 ticks y=0; the 12th tick frees slot0 with hit_valid never set.
REQ-039 Scenario: alive bit 4*6+3 set, fire at x=3 -> the tick that would give ny=4 produces hit_valid=1, hit_row=4, hit_col=3; slot0 is freed; with hit_ready=1 the report clears in the next cycle.
REQ-040 Scenario: COOLDOWN=2, fire pulses on consecutive cycles -> second is dropped; a fire after 2 ticks is accepted into slot1; a 4th fire with all 3 slots active gets no ack.
REQ-041 Scenario: two bullets hit the same tick, hit_ready=0 -> slot0 is reported and slot1 stalls at the same y; 3 ticks later hit_ready=1 -> slot1 is reported on the next tick after the drain.
REQ-042 Scenario: rst pulse while 2 bullets are in flight and hit_valid=1 -> all outputs read 0 immediately, with no hit handshake.
REQ-043 Scenario (BULLET_SCORE_EN): hit_ready held 1 over 256 hits -> score reads 255 and stays there.
